// File: rtl/if_stage_skid.sv
// if_stage_skid: instruction-fetch stage with a two-entry {pc, inst} buffer
// (main + skid register) between the pre-IF PC generator and decode.
// fs_stall is decoded purely from registers, so ds_allowin never reaches
// the PC logic combinationally.
// Optional feature macro: FS_ADEF_CHECK_EN (fetch-address alignment fault;
// a faulting fetch captures NOP_INST and raises fs_to_ds_excp).
module if_stage_skid #(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h03400000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pre_fs_valid,
  input  logic [PC_W-1:0]   pre_fs_pc,
  input  logic [INST_W-1:0] inst_sram_rdata,
  input  logic              br_taken_cancel,
  input  logic              ds_allowin,
  output logic              fs_stall,
  output logic              fs_to_ds_valid,
  output logic [PC_W-1:0]   fs_to_ds_pc,
  output logic [INST_W-1:0] fs_to_ds_inst,
  output logic              fs_to_ds_excp
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e              state_r;
  state_e              state_nxt_s;
  logic                valid_r;
  logic                stall_r;
  logic [PC_W-1:0]     main_pc_r;
  logic [INST_W-1:0]   main_inst_r;
  logic                main_excp_r;
  logic [PC_W-1:0]     skid_pc_r;
  logic [INST_W-1:0]   skid_inst_r;
  logic                skid_excp_r;

  logic                in_fire_s;
  logic                out_fire_s;
  logic                in_excp_s;
  logic [INST_W-1:0]   in_inst_s;
  logic                load_main_s;
  logic                load_skid_s;
  logic                shift_s;

  // The SRAM word is only valid in the cycle the PC is presented, so the
  // entry is formed here and captured on in_fire; never re-sampled later.
`ifdef FS_ADEF_CHECK_EN
  assign in_excp_s = (pre_fs_pc[1:0] != 2'b00);
  assign in_inst_s = in_excp_s ? NOP_INST : inst_sram_rdata;
`else
  assign in_excp_s = 1'b0;
  assign in_inst_s = inst_sram_rdata;
`endif

  // A cancel kills both handshakes: nothing enters and nothing leaves.
  assign in_fire_s  = pre_fs_valid & ~stall_r & ~br_taken_cancel;
  assign out_fire_s = valid_r & ds_allowin & ~br_taken_cancel;

  // Next-state and datapath-steering decode, cancel taking priority.
  always_comb begin
    state_nxt_s = state_r;
    load_main_s = 1'b0;
    load_skid_s = 1'b0;
    shift_s     = 1'b0;
    if (br_taken_cancel) begin
      state_nxt_s = S_EMPTY;
    end else begin
      case (state_r)
        S_EMPTY: begin
          if (in_fire_s) begin
            load_main_s = 1'b1;
            state_nxt_s = S_ONE;
          end else begin
            state_nxt_s = S_EMPTY;
          end
        end
        S_ONE: begin
          if (in_fire_s && out_fire_s) begin
            load_main_s = 1'b1;
            state_nxt_s = S_ONE;
          end else if (in_fire_s) begin
            load_skid_s = 1'b1;
            state_nxt_s = S_FULL;
          end else if (out_fire_s) begin
            state_nxt_s = S_EMPTY;
          end else begin
            state_nxt_s = S_ONE;
          end
        end
        S_FULL: begin
          // in_fire cannot occur here: fs_stall is high while FULL.
          if (out_fire_s) begin
            shift_s     = 1'b1;
            state_nxt_s = S_ONE;
          end else begin
            state_nxt_s = S_FULL;
          end
        end
        default: begin
          state_nxt_s = S_EMPTY;
        end
      endcase
    end
  end

  // Occupancy register plus valid/stall flags registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_EMPTY;
      valid_r <= 1'b0;
      stall_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      valid_r <= (state_nxt_s != S_EMPTY);
      stall_r <= (state_nxt_s == S_FULL);
    end
  end

  // Main entry: loaded from the input or promoted from the skid; otherwise
  // holds, so pc/inst/excp keep their last values while empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_pc_r   <= {PC_W{1'b0}};
      main_inst_r <= {INST_W{1'b0}};
      main_excp_r <= 1'b0;
    end else if (load_main_s) begin
      main_pc_r   <= pre_fs_pc;
      main_inst_r <= in_inst_s;
      main_excp_r <= in_excp_s;
    end else if (shift_s) begin
      main_pc_r   <= skid_pc_r;
      main_inst_r <= skid_inst_r;
      main_excp_r <= skid_excp_r;
    end
  end

  // Skid entry: catches the second in-flight fetch while decode is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_pc_r   <= {PC_W{1'b0}};
      skid_inst_r <= {INST_W{1'b0}};
      skid_excp_r <= 1'b0;
    end else if (load_skid_s) begin
      skid_pc_r   <= pre_fs_pc;
      skid_inst_r <= in_inst_s;
      skid_excp_r <= in_excp_s;
    end
  end

  assign fs_stall       = stall_r;
  assign fs_to_ds_valid = valid_r;
  assign fs_to_ds_pc    = main_pc_r;
  assign fs_to_ds_inst  = main_inst_r;
  assign fs_to_ds_excp  = main_excp_r;

endmodule

// File: tb/tb_if_stage_skid.sv
// Scoreboard bench for if_stage_skid. The bench plays the pre-IF stage
// (PC advances by 4 only on an accepted fetch) and keeps a queue model of
// the two-entry buffer; DUT outputs are compared on the falling edge.
module tb_if_stage_skid;

  logic        clk;
  logic        reset;
  logic        pre_fs_valid;
  logic [31:0] pre_fs_pc;
  logic [31:0] inst_sram_rdata;
  logic        br_taken_cancel;
  logic        ds_allowin;
  logic        fs_stall;
  logic        fs_to_ds_valid;
  logic [31:0] fs_to_ds_pc;
  logic [31:0] fs_to_ds_inst;
  logic        fs_to_ds_excp;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] pf_pc;
  int          n_checks;
  int          n_pass;

  if_stage_skid dut (
    .clk             (clk),
    .reset           (reset),
    .pre_fs_valid    (pre_fs_valid),
    .pre_fs_pc       (pre_fs_pc),
    .inst_sram_rdata (inst_sram_rdata),
    .br_taken_cancel (br_taken_cancel),
    .ds_allowin      (ds_allowin),
    .fs_stall        (fs_stall),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_pc     (fs_to_ds_pc),
    .fs_to_ds_inst   (fs_to_ds_inst),
    .fs_to_ds_excp   (fs_to_ds_excp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic exp_excp(input logic [31:0] pc);
`ifdef FS_ADEF_CHECK_EN
    return (pc[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return exp_excp(pc) ? 32'h03400000 : rd_of(pc);
  endfunction

  // Applies one cycle of stimulus (called at a falling edge), updates the
  // model for the coming rising edge, then waits for the next falling edge.
  task automatic drive(input logic pv, input logic cancel, input logic allow);
    logic mv, ms, inf, outf;
    ent_t e;
    mv = (mq.size() != 0);
    ms = (mq.size() == 2);
    pre_fs_valid    = pv;
    pre_fs_pc       = pf_pc;
    inst_sram_rdata = rd_of(pf_pc);
    br_taken_cancel = cancel;
    ds_allowin      = allow;
    inf  = pv & ~ms & ~cancel;
    outf = mv & allow & ~cancel;
    if (cancel) begin
      mq.delete();
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf) begin
        e.pc = pf_pc; e.inst = exp_inst(pf_pc); e.excp = exp_excp(pf_pc);
        mq.push_back(e);
      end
    end
    if (inf) pf_pc = pf_pc + 32'd4;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++; if (fs_to_ds_valid !== 1'b0) $display("FAIL rst_valid got=%b want=0", fs_to_ds_valid); else n_pass++;
    n_checks++; if (fs_stall !== 1'b0) $display("FAIL rst_stall got=%b want=0", fs_stall); else n_pass++;
    n_checks++; if (fs_to_ds_pc !== 32'h0) $display("FAIL rst_pc got=%h want=0", fs_to_ds_pc); else n_pass++;
    n_checks++; if (fs_to_ds_inst !== 32'h0) $display("FAIL rst_inst got=%h want=0", fs_to_ds_inst); else n_pass++;
    n_checks++; if (fs_to_ds_excp !== 1'b0) $display("FAIL rst_excp got=%b want=0", fs_to_ds_excp); else n_pass++;
  endtask

  task automatic test_stream();
    pf_pc = 32'h1c000000;
    for (int i = 0; i < 5; i++) begin
      drive((i < 4) ? 1'b1 : 1'b0, 1'b0, 1'b1);
      n_checks++; if (fs_to_ds_valid !== (mq.size() != 0)) $display("FAIL stream_valid[%0d] got=%b want=%b", i, fs_to_ds_valid, mq.size() != 0); else n_pass++;
      n_checks++; if (fs_stall !== 1'b0) $display("FAIL stream_stall[%0d] got=%b want=0", i, fs_stall); else n_pass++;
      if (mq.size() != 0) begin
        n_checks++; if (fs_to_ds_pc !== mq[0].pc) $display("FAIL stream_pc[%0d] got=%h want=%h", i, fs_to_ds_pc, mq[0].pc); else n_pass++;
        n_checks++; if (fs_to_ds_inst !== mq[0].inst) $display("FAIL stream_inst[%0d] got=%h want=%h", i, fs_to_ds_inst, mq[0].inst); else n_pass++;
      end
    end
    drive(1'b0, 1'b0, 1'b1);
    n_checks++; if (fs_to_ds_valid !== 1'b0) $display("FAIL stream_drained got=%b want=0", fs_to_ds_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] allow_tab;
    allow_tab = 8'b1110_0011; // bit i = ds_allowin in cycle i
    pf_pc = 32'h1c000000;
    for (int i = 0; i < 8; i++) begin
      drive((i < 6) ? 1'b1 : 1'b0, 1'b0, allow_tab[i]);
      n_checks++; if (fs_to_ds_valid !== (mq.size() != 0)) $display("FAIL bp_valid[%0d] got=%b want=%b", i, fs_to_ds_valid, mq.size() != 0); else n_pass++;
      n_checks++; if (fs_stall !== (mq.size() == 2)) $display("FAIL bp_stall[%0d] got=%b want=%b", i, fs_stall, mq.size() == 2); else n_pass++;
      if (mq.size() != 0) begin
        n_checks++; if (fs_to_ds_pc !== mq[0].pc) $display("FAIL bp_pc[%0d] got=%h want=%h", i, fs_to_ds_pc, mq[0].pc); else n_pass++;
        n_checks++; if (fs_to_ds_inst !== mq[0].inst) $display("FAIL bp_inst[%0d] got=%h want=%h", i, fs_to_ds_inst, mq[0].inst); else n_pass++;
      end
      if (i == 2) begin
        n_checks++; if (fs_stall !== 1'b1 || fs_to_ds_pc !== 32'h1c000004) $display("FAIL bp_full stall=%b pc=%h want stall=1 pc=1c000004", fs_stall, fs_to_ds_pc); else n_pass++;
      end
    end
    while (mq.size() != 0) drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_cancel_full();
    pf_pc = 32'h1c000040;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    n_checks++; if (fs_stall !== 1'b1) $display("FAIL cf_setup_stall got=%b want=1", fs_stall); else n_pass++;
    pf_pc = 32'h1c000010;
    drive(1'b1, 1'b1, 1'b0);
    n_checks++; if (fs_to_ds_valid !== 1'b0) $display("FAIL cf_valid got=%b want=0", fs_to_ds_valid); else n_pass++;
    n_checks++; if (fs_stall !== 1'b0) $display("FAIL cf_stall got=%b want=0", fs_stall); else n_pass++;
    pf_pc = 32'h1c000100;
    drive(1'b1, 1'b0, 1'b0);
    n_checks++; if (fs_to_ds_valid !== 1'b1) $display("FAIL cf_tgt_valid got=%b want=1", fs_to_ds_valid); else n_pass++;
    n_checks++; if (fs_to_ds_pc !== 32'h1c000100) $display("FAIL cf_tgt_pc got=%h want=1c000100", fs_to_ds_pc); else n_pass++;
    n_checks++; if (fs_to_ds_pc !== mq[0].pc || fs_to_ds_inst !== mq[0].inst) $display("FAIL cf_tgt_sb got=%h/%h want=%h/%h", fs_to_ds_pc, fs_to_ds_inst, mq[0].pc, mq[0].inst); else n_pass++;
  endtask

  task automatic test_cancel_one();
    // One entry (0x1c000100) is held from the previous task.
    n_checks++; if (fs_to_ds_valid !== 1'b1 || fs_stall !== 1'b0) $display("FAIL co_setup valid=%b stall=%b want 1/0", fs_to_ds_valid, fs_stall); else n_pass++;
    drive(1'b0, 1'b1, 1'b1);
    n_checks++; if (fs_to_ds_valid !== 1'b0) $display("FAIL co_valid got=%b want=0", fs_to_ds_valid); else n_pass++;
    drive(1'b0, 1'b0, 1'b1);
    n_checks++; if (fs_to_ds_valid !== (mq.size() != 0)) $display("FAIL co_stay_empty got=%b want=%b", fs_to_ds_valid, mq.size() != 0); else n_pass++;
  endtask

  task automatic test_excp();
    pf_pc = 32'h1c000002;
    drive(1'b1, 1'b0, 1'b0);
    n_checks++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_pc !== 32'h1c000002) $display("FAIL ex_entry valid=%b pc=%h want 1/1c000002", fs_to_ds_valid, fs_to_ds_pc); else n_pass++;
`ifdef FS_ADEF_CHECK_EN
    n_checks++; if (fs_to_ds_excp !== 1'b1) $display("FAIL ex_excp got=%b want=1", fs_to_ds_excp); else n_pass++;
    n_checks++; if (fs_to_ds_inst !== 32'h03400000) $display("FAIL ex_inst got=%h want=03400000", fs_to_ds_inst); else n_pass++;
`else
    n_checks++; if (fs_to_ds_excp !== 1'b0) $display("FAIL ex_excp got=%b want=0", fs_to_ds_excp); else n_pass++;
    n_checks++; if (fs_to_ds_inst !== (32'h1c000002 ^ 32'hA5A5_0F0F)) $display("FAIL ex_inst got=%h want=%h", fs_to_ds_inst, 32'h1c000002 ^ 32'hA5A5_0F0F); else n_pass++;
`endif
    pf_pc = 32'h1c000200;
    drive(1'b1, 1'b0, 1'b1);
    n_checks++; if (fs_to_ds_excp !== 1'b0 || fs_to_ds_inst !== rd_of(32'h1c000200)) $display("FAIL ex_aligned excp=%b inst=%h want 0/%h", fs_to_ds_excp, fs_to_ds_inst, rd_of(32'h1c000200)); else n_pass++;
    while (mq.size() != 0) drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midcycle();
    pf_pc = 32'h1c000020;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    n_checks++; if (fs_stall !== 1'b1) $display("FAIL rm_setup_stall got=%b want=1", fs_stall); else n_pass++;
    #2 reset = 1'b1;
    #1;
    mq.delete();
    n_checks++; if (fs_to_ds_valid !== 1'b0 || fs_stall !== 1'b0) $display("FAIL rm_ctl valid=%b stall=%b want 0/0", fs_to_ds_valid, fs_stall); else n_pass++;
    n_checks++; if (fs_to_ds_pc !== 32'h0 || fs_to_ds_inst !== 32'h0 || fs_to_ds_excp !== 1'b0) $display("FAIL rm_data pc=%h inst=%h excp=%b want 0", fs_to_ds_pc, fs_to_ds_inst, fs_to_ds_excp); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    pf_pc = 32'h1c000000;
    drive(1'b1, 1'b0, 1'b1);
    n_checks++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_pc !== 32'h1c000000) $display("FAIL rm_first valid=%b pc=%h want 1/1c000000", fs_to_ds_valid, fs_to_ds_pc); else n_pass++;
    n_checks++; if (fs_to_ds_inst !== mq[0].inst) $display("FAIL rm_first_inst got=%h want=%h", fs_to_ds_inst, mq[0].inst); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    pre_fs_valid = 1'b0;
    pre_fs_pc = 32'h0;
    inst_sram_rdata = 32'h0;
    br_taken_cancel = 1'b0;
    ds_allowin = 1'b0;
    pf_pc = 32'h0;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_stream();
    test_backpressure();
    test_cancel_full();
    test_cancel_one();
    test_excp();
    test_reset_midcycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
